ram_bist_seq: RTL and testbench

//  Parametrised RAM test sequencer; next generation of the testbench address/data generator.
//  On start: clears RAM, writes a pattern to every address, reads back, compares each word.

---
 rtl/ram_bist_pkg.sv | 41 ++++
 rtl/ram_pattern_gen.sv | 45 ++++
 rtl/ram_bist_seq.sv | 191 +++++++++++++++++++
 tb/tb_ram_bist_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared constants and pattern helpers for the ram_bist_seq RAM test sequencer.
package ram_bist_pkg;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClr   = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
  localparam logic [2:0] StRead  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [1:0] ModeAddr = 2'd0;
  localparam logic [1:0] ModeInv  = 2'd1;
  localparam logic [1:0] ModeChk  = 2'd2;
  localparam logic [1:0] ModeLfsr = 2'd3;

  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LfsrTaps : 16'h0000);
  endfunction

  // Result is 16 bits wide; callers keep the low dw bits.
  function automatic logic [15:0] pattern(input logic [1:0] mode, input logic [15:0] addr,
                                          input logic [15:0] lfsr, input int unsigned dw);
    logic [15:0] chk;
    for (int i = 0; i < 16; i++) begin
      chk[i] = (i % 2 == 1) ^ addr[0];
    end
    // Odd widths: the leftover MSB follows the inverse of the address parity.
    if (dw % 2 == 1) begin
      chk[4'(dw - 1)] = ~addr[0];
    end
    case (mode)
      ModeAddr: pattern = addr;
      ModeInv:  pattern = ~addr;
      ModeChk:  pattern = chk;
      default:  pattern = lfsr;
    endcase
  endfunction

endpackage

// File: rtl/ram_pattern_gen.sv
// Pattern source for ram_bist_seq: latches the mode on start and owns the Galois LFSR.
module ram_pattern_gen
  import ram_bist_pkg::*;
#(
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 8,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          latch_i,
  input  logic [1:0]    mode_i,
  input  logic          load_seed_i,
  input  logic          step_i,
  input  logic [AW-1:0] addr_i,
  output logic [DW-1:0] data_o
);

  logic [1:0]  mode_q;
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_seed_i) begin
      lfsr_d = SEED;
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q <= ModeAddr;
      lfsr_q <= SEED;
    end else begin
      if (latch_i) begin
        mode_q <= mode_i;
      end
      lfsr_q <= lfsr_d;
    end
  end

  assign data_o = DW'(pattern(mode_q, 16'(addr_i), lfsr_q, DW));

endmodule

// File: rtl/ram_bist_seq.sv
// RAM test sequencer: clear, write a pattern sweep, read back and count mismatches.
// Define RAM_BIST_ERR_LOG_EN to add first-error address/data capture outputs.
module ram_bist_seq
  import ram_bist_pkg::*;
#(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 8,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             ram_aclr_o,
  output logic             ram_wren_o,
  output logic [AW-1:0]    ram_addr_o,
  output logic [DW-1:0]    ram_data_o,
  input  logic [DW-1:0]    ram_q_i
`ifdef RAM_BIST_ERR_LOG_EN
  ,
  output logic [AW-1:0]    first_err_addr_o,
  output logic [DW-1:0]    first_err_data_o,
  output logic             err_seen_o
`endif
);

  localparam logic [AW-1:0] LastAddr = {AW{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [2:0]       drain_q, drain_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic [DW-1:0]    exp_q [RD_LAT];
  logic [RD_LAT-1:0] vld_q;
  logic             start_ok, load_seed, step, mismatch;
  logic [DW-1:0]    pat;

  assign start_ok = (state_q == StIdle) && start_i;

  ram_pattern_gen #(
    .AW   (AW),
    .DW   (DW),
    .SEED (SEED)
  ) u_pattern_gen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .latch_i     (start_ok),
    .mode_i      (mode_i),
    .load_seed_i (load_seed),
    .step_i      (step),
    .addr_i      (addr_q),
    .data_o      (pat)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    drain_d   = drain_q;
    load_seed = 1'b0;
    step      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) state_d = StClr;
      end
      StClr: begin
        state_d   = StWrite;
        addr_d    = '0;
        load_seed = 1'b1;
      end
      StWrite: begin
        // Reseed so the read sweep regenerates the write sequence.
        if (addr_q == LastAddr) begin
          state_d   = StRead;
          addr_d    = '0;
          load_seed = 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
          step   = 1'b1;
        end
      end
      StRead: begin
        if (addr_q == LastAddr) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          addr_d = addr_q + 1'b1;
          step   = 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == 3'(RD_LAT - 1)) state_d = StDone;
        else drain_d = drain_q + 3'd1;
      end
      StDone: begin
        state_d = StIdle;
        addr_d  = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mismatch = vld_q[RD_LAT-1] && (ram_q_i != exp_q[RD_LAT-1]);

  always_comb begin
    err_d  = err_q;
    pass_d = pass_q;
    if (start_ok) begin
      err_d  = '0;
      pass_d = 1'b0;
    end else if (mismatch && (err_q != {CNT_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
    // The last compare lands on the same edge that enters DONE.
    if (state_q == StDrain && state_d == StDone) begin
      pass_d = (err_d == '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      drain_q <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) exp_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
      end
      vld_q[0] <= (state_q == StRead);
      exp_q[0] <= pat;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StDone);
  assign pass_o     = pass_q;
  assign err_cnt_o  = err_q;
  assign ram_aclr_o = (state_q == StClr);
  assign ram_wren_o = (state_q == StWrite);
  assign ram_addr_o = addr_q;
  assign ram_data_o = (state_q == StWrite) ? pat : '0;

`ifdef RAM_BIST_ERR_LOG_EN
  logic [AW-1:0] eaddr_q [RD_LAT];
  logic [AW-1:0] fea_q;
  logic [DW-1:0] fed_q;
  logic          seen_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LAT; i++) eaddr_q[i] <= '0;
      fea_q  <= '0;
      fed_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) eaddr_q[i] <= eaddr_q[i-1];
      eaddr_q[0] <= addr_q;
      if (start_ok) begin
        fea_q  <= '0;
        fed_q  <= '0;
        seen_q <= 1'b0;
      end else if (mismatch && !seen_q) begin
        fea_q  <= eaddr_q[RD_LAT-1];
        fed_q  <= ram_q_i;
        seen_q <= 1'b1;
      end
    end
  end

  assign first_err_addr_o = fea_q;
  assign first_err_data_o = fed_q;
  assign err_seen_o       = seen_q;
`endif

endmodule

// File: tb/tb_ram_bist_seq.sv
// Self-checking bench for ram_bist_seq: two configurations, behavioural RAM and pattern model.
module tb_ram_bist_seq;

  localparam int Depth = 256;

  typedef struct {
    logic       s;
    logic [1:0] m;
    int         fault;
    int         exp_err;
    logic       exp_pass;
    string      tag;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, sel, zero_ram;
  logic [1:0] mode;
  logic       start0, start1;

  logic       busy0, done0, pass0, aclr0, wren0;
  logic [7:0] err0, addr0, data0, q0;
  logic       busy1, done1, pass1, aclr1, wren1;
  logic [3:0] err1;
  logic [7:0] addr1, data1, q1, p1;

  logic       busy_s, done_s, pass_s, aclr_s, wren_s;
  logic [7:0] err_s, addr_s, data_s;

  logic [7:0] mem0 [Depth];
  logic [7:0] mem1 [Depth];
  logic [7:0] flip [Depth];
  logic [7:0] exp_pat [Depth];
  logic [7:0] cap [4];

  int checks = 0;
  int errors = 0;

`ifdef RAM_BIST_ERR_LOG_EN
  logic [7:0] fea0, fed0, fea1, fed1, fea_s, fed_s;
  logic       seen0, seen1, seen_s;
`endif

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  ram_bist_seq #(.AW(8), .DW(8), .RD_LAT(1), .CNT_W(8), .SEED(16'hACE1)) u_dut0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start0),
    .mode_i     (mode),
    .busy_o     (busy0),
    .done_o     (done0),
    .pass_o     (pass0),
    .err_cnt_o  (err0),
    .ram_aclr_o (aclr0),
    .ram_wren_o (wren0),
    .ram_addr_o (addr0),
    .ram_data_o (data0),
    .ram_q_i    (q0)
`ifdef RAM_BIST_ERR_LOG_EN
    ,
    .first_err_addr_o (fea0),
    .first_err_data_o (fed0),
    .err_seen_o       (seen0)
`endif
  );

  ram_bist_seq #(.AW(8), .DW(8), .RD_LAT(2), .CNT_W(4), .SEED(16'hACE1)) u_dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start1),
    .mode_i     (mode),
    .busy_o     (busy1),
    .done_o     (done1),
    .pass_o     (pass1),
    .err_cnt_o  (err1),
    .ram_aclr_o (aclr1),
    .ram_wren_o (wren1),
    .ram_addr_o (addr1),
    .ram_data_o (data1),
    .ram_q_i    (q1)
`ifdef RAM_BIST_ERR_LOG_EN
    ,
    .first_err_addr_o (fea1),
    .first_err_data_o (fed1),
    .err_seen_o       (seen1)
`endif
  );

  always_comb begin
    if (sel) begin
      busy_s = busy1; done_s = done1; pass_s = pass1; aclr_s = aclr1; wren_s = wren1;
      err_s = {4'h0, err1}; addr_s = addr1; data_s = data1;
    end else begin
      busy_s = busy0; done_s = done0; pass_s = pass0; aclr_s = aclr0; wren_s = wren0;
      err_s = err0; addr_s = addr0; data_s = data0;
    end
`ifdef RAM_BIST_ERR_LOG_EN
    fea_s  = sel ? fea1 : fea0;
    fed_s  = sel ? fed1 : fed0;
    seen_s = sel ? seen1 : seen0;
`endif
  end

  // RAM models: synchronous, clear-all on aclr, read faults injected on the output path.
  always @(posedge clk) begin
    if (aclr0) for (int i = 0; i < Depth; i++) mem0[i] <= 8'h00;
    else if (wren0) mem0[addr0] <= data0;
    q0 <= zero_ram ? 8'h00 : (mem0[addr0] ^ flip[addr0]);
  end

  always @(posedge clk) begin
    if (aclr1) for (int i = 0; i < Depth; i++) mem1[i] <= 8'h00;
    else if (wren1) mem1[addr1] <= data1;
    p1 <= zero_ram ? 8'h00 : (mem1[addr1] ^ flip[addr1]);
    q1 <= p1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic build_pat(input logic [1:0] m);
    logic [15:0] x;
    x = 16'hACE1;
    for (int a = 0; a < Depth; a++) begin
      case (m)
        2'd0: exp_pat[a] = 8'(a);
        2'd1: exp_pat[a] = 8'(255 - a);
        2'd2: exp_pat[a] = (a % 2 == 0) ? 8'hAA : 8'h55;
        default: begin
          exp_pat[a] = x[7:0];
          x = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
        end
      endcase
    end
  endtask

  task automatic model_err(output int cnt, output int fa, output int fd);
    logic [7:0] obs;
    cnt = 0; fa = 0; fd = 0;
    for (int a = 0; a < Depth; a++) begin
      obs = zero_ram ? 8'h00 : (exp_pat[a] ^ flip[a]);
      if (obs != exp_pat[a]) begin
        if (cnt == 0) begin
          fa = a;
          fd = int'(obs);
        end
        cnt++;
      end
    end
  endtask

  task automatic clear_faults();
    zero_ram = 1'b0;
    for (int a = 0; a < Depth; a++) flip[a] = 8'h00;
  endtask

  task automatic run(input logic s, input logic [1:0] m, input int exp_err, input logic exp_pass,
                     input int rep_at, input string tag);
    int  n, lim, wr_n, wr_bad, clr_n, cnt, fa, fd;
    bit  got;
    sel = s;
    build_pat(m);
    model_err(cnt, fa, fd);
    lim = 2 * Depth + (s ? 2 : 1) + 2;
    @(negedge clk);
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = ~m;
    n = 1; wr_n = 0; wr_bad = 0; clr_n = 0; got = 0;
    chk({tag, "_busy"}, int'(busy_s), 1);
    while (!got && n < lim + 20) begin
      if (aclr_s) clr_n++;
      if (wren_s) begin
        wr_n++;
        if (data_s !== exp_pat[addr_s]) wr_bad++;
        if (addr_s < 8'd3) cap[addr_s[1:0]] = data_s;
      end
      if (done_s) got = 1;
      else begin
        @(negedge clk);
        n++;
        start = (n == rep_at);
      end
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, got ? n : -1, lim);
    chk({tag, "_err_cnt"}, int'(err_s), exp_err);
    chk({tag, "_pass"}, int'(pass_s), int'(exp_pass));
    chk({tag, "_writes"}, wr_n, Depth);
    chk({tag, "_wdata_bad"}, wr_bad, 0);
    chk({tag, "_aclr_cycles"}, clr_n, 1);
`ifdef RAM_BIST_ERR_LOG_EN
    chk({tag, "_err_seen"}, int'(seen_s), (cnt != 0) ? 1 : 0);
    if (cnt != 0) begin
      chk({tag, "_first_addr"}, int'(fea_s), fa);
      chk({tag, "_first_data"}, int'(fed_s), fd);
    end
`endif
    @(negedge clk);
    chk({tag, "_done_low"}, int'(done_s), 0);
    chk({tag, "_busy_low"}, int'(busy_s), 0);
    chk({tag, "_pass_hold"}, int'(pass_s), int'(exp_pass));
  endtask

  initial begin
    vec_t tbl [9];
    int   cnt, fa, fd, dn, k;
    logic s;
    logic [1:0] m;

    tbl[0] = '{1'b0, 2'd0, 0, 0,   1'b1, "m0_ideal"};
    tbl[1] = '{1'b1, 2'd3, 0, 0,   1'b1, "m3_lat2_ideal"};
    tbl[2] = '{1'b0, 2'd0, 1, 1,   1'b0, "m0_bit0_at_10"};
    tbl[3] = '{1'b1, 2'd1, 2, 15,  1'b0, "m1_cnt4_sat"};
    tbl[4] = '{1'b0, 2'd2, 2, 255, 1'b0, "m2_zero_sat"};
    tbl[5] = '{1'b0, 2'd0, 2, 255, 1'b0, "m0_zero_255"};
    tbl[6] = '{1'b1, 2'd0, 1, 1,   1'b0, "m0_lat2_bit0"};
    tbl[7] = '{1'b1, 2'd2, 0, 0,   1'b1, "m2_lat2_ideal"};
    tbl[8] = '{1'b0, 2'd3, 0, 0,   1'b1, "m3_ideal"};

    rst = 1'b1; start = 1'b0; sel = 1'b0; mode = 2'd0;
    clear_faults();
    repeat (3) @(negedge clk);
    chk("reset_dut0", int'({busy0, done0, pass0, aclr0, wren0, err0, addr0, data0}), 0);
    chk("reset_dut1", int'({busy1, done1, pass1, aclr1, wren1, err1, addr1, data1}), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      clear_faults();
      if (tbl[i].fault == 1) flip[8'h10] = 8'h01;
      if (tbl[i].fault == 2) zero_ram = 1'b1;
      run(tbl[i].s, tbl[i].m, tbl[i].exp_err, tbl[i].exp_pass, 0, tbl[i].tag);
      if (i == 1) begin
        chk("lfsr_word0", int'(cap[0]), 8'hE1);
        chk("lfsr_word1", int'(cap[1]), 8'h70);
        chk("lfsr_word2", int'(cap[2]), 8'h38);
      end
    end

    clear_faults();
    run(1'b0, 2'd0, 0, 1'b1, 101, "restart_ignored");

    // Reset in the middle of the read sweep while errors are accumulating.
    clear_faults();
    zero_ram = 1'b1;
    sel = 1'b0;
    @(negedge clk);
    mode = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 300; n++) @(negedge clk);
    chk("mid_busy_before", int'(busy_s), 1);
    chk("mid_err_nonzero", int'(err_s != 8'h00), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out", int'({busy0, done0, pass0, aclr0, wren0, err0, addr0, data0}), 0);
`ifdef RAM_BIST_ERR_LOG_EN
    chk("mid_rst_log", int'({fea0, fed0, seen0}), 0);
`endif
    rst = 1'b0;
    dn = 0;
    repeat (600) begin
      @(negedge clk);
      if (done_s) dn++;
    end
    chk("mid_no_done", dn, 0);
    clear_faults();
    run(1'b0, 2'd0, 0, 1'b1, 0, "after_rst");

    for (int r = 0; r < 6; r++) begin
      clear_faults();
      s = 1'($urandom_range(0, 1));
      m = 2'($urandom_range(0, 3));
      k = $urandom_range(0, 24);
      for (int j = 0; j < k; j++) flip[$urandom_range(0, Depth - 1)] = 8'($urandom_range(1, 255));
      sel = s;
      build_pat(m);
      model_err(cnt, fa, fd);
      if (s && cnt > 15) cnt = 15;
      if (!s && cnt > 255) cnt = 255;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run(s, m, cnt, (cnt == 0), 0, $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
